// File: rtl/mem_arbiter_sp.sv
// Two-port (instruction/data) arbiter in front of a single-port synchronous RAM.
// Data has priority; a bounded starve counter guarantees instruction progress.
module mem_arbiter_sp #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BYTES   = DATA_WIDTH / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_i_req,
  input  logic [ADDR_WIDTH-1:0] i_i_addr,
  output logic                  o_i_gnt,
  output logic                  o_i_rvalid,
  output logic [DATA_WIDTH-1:0] o_i_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [DATA_BYTES-1:0] i_d_be,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  owner_e                owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  starved;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    o_i_gnt    = 1'b0;
    o_d_gnt    = 1'b0;
    owner_d    = OWN_NONE;
    starve_d   = starve_q;
    o_mem_addr = addr_q;
    o_mem_wen  = '0;
    starved    = (starve_q == LIMIT);

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    if (rst_n) begin
      o_i_gnt = i_i_req && (!i_d_req || starved);
      o_d_gnt = i_d_req && !o_i_gnt;
    end

    if (o_i_gnt) begin
      owner_d    = OWN_I;
      o_mem_addr = i_i_addr;
    end else if (o_d_gnt) begin
      owner_d    = OWN_D;
      o_mem_addr = i_d_addr;
      if (i_d_we) o_mem_wen = i_d_be;
    end

    // The counter only tracks consecutive data wins against a waiting fetch.
    if (!i_i_req || o_i_gnt) starve_d = '0;
    else if (o_d_gnt && starve_q < LIMIT) starve_d = starve_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      addr_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= o_mem_addr;
    end
  end

  assign o_i_rvalid  = (owner_q == OWN_I);
  assign o_d_rvalid  = (owner_q == OWN_D);
  assign o_i_rdata   = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;
  assign o_mem_wdata = i_d_wdata;

endmodule

// File: tb/tb_mem_arbiter_sp.sv
// Directed bench for mem_arbiter_sp with a write-first byte-enabled RAM model.
module tb_mem_arbiter_sp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [10:0] i_addr, d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic [3:0]  mem_wen;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter_sp #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(i_gnt),
    .o_i_rvalid(i_rvalid), .o_i_rdata(i_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
    .i_mem_rdata(mem_rdata)
  );

  // RAM model: word k resets to A500_0000|k, except 0x020 which holds 0x11223344.
  logic [31:0] mem [2048];
  logic [31:0] wr_word;

  always_comb begin
    wr_word = mem[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) wr_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2048; k++) mem[k] <= 32'hA500_0000 | 32'(k);
      mem[11'h020] <= 32'h1122_3344;
      mem_rdata    <= '0;
    end else begin
      mem[mem_addr] <= wr_word;
      mem_rdata     <= wr_word;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [10:0] ia, input logic dr, input logic we,
                       input logic [3:0] be, input logic [10:0] da, input logic [31:0] wd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
  endtask

  typedef struct {
    string       name;
    logic        i_req;
    logic [10:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  be;
    logic [10:0] d_addr;
    logic [31:0] wdata;
    logic        e_ig;
    logic        e_dg;
    logic [10:0] e_addr;
    logic [3:0]  e_wen;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Directed vectors, applied in order; the memory effects of earlier writes carry forward.
    vecs[0] = '{"i_only",    1, 11'h010, 0, 0, 4'h0, 11'h000, 32'h0,         1, 0, 11'h010, 4'h0, 32'hA500_0010};
    vecs[1] = '{"byte_wr",   0, 11'h000, 1, 1, 4'h2, 11'h020, 32'hAABBCCDD,  0, 1, 11'h020, 4'h2, 32'h1122_CC44};
    vecs[2] = '{"rd_back",   0, 11'h000, 1, 0, 4'h0, 11'h020, 32'h0,         0, 1, 11'h020, 4'h0, 32'h1122_CC44};
    vecs[3] = '{"idle_hold", 0, 11'h3FF, 0, 1, 4'hF, 11'h3FE, 32'h0,         0, 0, 11'h020, 4'h0, 32'h0};
    vecs[4] = '{"word_wr",   0, 11'h000, 1, 1, 4'hF, 11'h030, 32'hDEADBEEF,  0, 1, 11'h030, 4'hF, 32'hDEADBEEF};
    vecs[5] = '{"i_after_w", 1, 11'h030, 0, 0, 4'h0, 11'h000, 32'h0,         1, 0, 11'h030, 4'h0, 32'hDEADBEEF};
    vecs[6] = '{"be_1001",   0, 11'h000, 1, 1, 4'h9, 11'h031, 32'h12345678,  0, 1, 11'h031, 4'h9, 32'h1200_0078};
    vecs[7] = '{"rd_be_ign", 0, 11'h000, 1, 0, 4'hF, 11'h031, 32'hFFFFFFFF,  0, 1, 11'h031, 4'h0, 32'h1200_0078};
    vecs[8] = '{"both_d1st", 1, 11'h040, 1, 0, 4'h0, 11'h041, 32'h0,         0, 1, 11'h041, 4'h0, 32'hA500_0041};
    vecs[9] = '{"i_after",   1, 11'h040, 0, 0, 4'h0, 11'h000, 32'h0,         1, 0, 11'h040, 4'h0, 32'hA500_0040};

    rst_n = 1'b0;
    drive(1, 11'h123, 1, 1, 4'hF, 11'h456, 32'h0);
    #1;
    check("rst_i_gnt", 32'(i_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_wen", 32'(mem_wen), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("rel_rvalid", {30'b0, i_rvalid, d_rvalid}, 0);

    foreach (vecs[v]) begin
      @(negedge clk);
      drive(vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_we,
            vecs[v].be, vecs[v].d_addr, vecs[v].wdata);
      #1;
      check({vecs[v].name, ".i_gnt"}, 32'(i_gnt), 32'(vecs[v].e_ig));
      check({vecs[v].name, ".d_gnt"}, 32'(d_gnt), 32'(vecs[v].e_dg));
      check({vecs[v].name, ".addr"}, 32'(mem_addr), 32'(vecs[v].e_addr));
      check({vecs[v].name, ".wen"}, 32'(mem_wen), 32'(vecs[v].e_wen));
      check({vecs[v].name, ".wdata"}, mem_wdata, vecs[v].wdata);
      @(posedge clk);
      #1;
      check({vecs[v].name, ".i_rvalid"}, 32'(i_rvalid), 32'(vecs[v].e_ig));
      check({vecs[v].name, ".d_rvalid"}, 32'(d_rvalid), 32'(vecs[v].e_dg));
      if (vecs[v].e_ig) check({vecs[v].name, ".i_rdata"}, i_rdata, vecs[v].e_rdata);
      if (vecs[v].e_dg) check({vecs[v].name, ".d_rdata"}, d_rdata, vecs[v].e_rdata);
    end

    // Continuous contention: four data wins, then the starved fetch, repeating.
    begin
      bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        drive(1, 11'h050, 1, 0, 0, 11'h051, 0);
        #1;
        check($sformatf("cont%0d.i_gnt", k), 32'(i_gnt), 32'(exp_i[k]));
        check($sformatf("cont%0d.d_gnt", k), 32'(d_gnt), 32'(!exp_i[k]));
        @(posedge clk);
        #1;
        check($sformatf("cont%0d.i_rvalid", k), 32'(i_rvalid), 32'(exp_i[k]));
        check($sformatf("cont%0d.rdata", k), i_rdata, exp_i[k] ? 32'hA500_0050 : 32'hA500_0051);
      end
    end

    // A single cycle with no fetch pending clears the counter mid-run.
    begin
      bit ir    [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      bit exp_i [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        drive(ir[k], 11'h060, 1, 0, 0, 11'h061, 0);
        #1;
        check($sformatf("clr%0d.i_gnt", k), 32'(i_gnt), 32'(exp_i[k]));
        check($sformatf("clr%0d.d_gnt", k), 32'(d_gnt), 32'(!exp_i[k]));
      end
    end

    // Alternating single requesters: one response per cycle on the right port.
    for (int k = 0; k < 6; k++) begin
      logic [10:0] a;
      a = (k % 2 == 0) ? 11'(11'h100 + k) : 11'(11'h200 + k);
      @(negedge clk);
      if (k % 2 == 0) drive(1, a, 0, 0, 0, 0, 0);
      else            drive(0, 0, 1, 0, 0, a, 0);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.rvalid", k), {30'b0, i_rvalid, d_rvalid},
            (k % 2 == 0) ? 32'd2 : 32'd1);
      check($sformatf("b2b%0d.rdata", k), (k % 2 == 0) ? i_rdata : d_rdata,
            32'hA500_0000 | 32'(a));
    end

    // Reset lands between a data grant and its response.
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 11'h070, 0);
    #1;
    check("mid.d_gnt", 32'(d_gnt), 1);
    #2;
    rst_n = 1'b0;
    drive(1, 11'h071, 1, 1, 4'hF, 11'h072, 32'h5555_5555);
    #1;
    check("mid.rvalid_async", {30'b0, i_rvalid, d_rvalid}, 0);
    check("mid.wen", 32'(mem_wen), 0);
    check("mid.gnt", {30'b0, i_gnt, d_gnt}, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid%0d.d_rvalid", k), 32'(d_rvalid), 0);
      check($sformatf("mid%0d.wen", k), 32'(mem_wen), 0);
      check($sformatf("mid%0d.starve", k), 32'(dut.starve_q), 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("post.addr", 32'(mem_addr), 0);
    @(posedge clk);
    #1;
    check("post.rvalid", {30'b0, i_rvalid, d_rvalid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_sp.md
MEM_ARBITER_SP -- requirements
Module: mem_arbiter_sp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, the word address width of the shared memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data word width.
REQ-003 SHALL have parameter DATA_BYTES, default DATA_WIDTH/8, the byte-enable width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: the maximum consecutive data grants while an instruction request waits.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_i_req, input, 1, instruction fetch request; held until granted.
REQ-008 SHALL have port i_i_addr, input, ADDR_WIDTH, instruction fetch word address.
REQ-009 SHALL have port o_i_gnt, output, 1, instruction request accepted this cycle.
REQ-010 SHALL have port o_i_rvalid, output, 1, instruction read data valid.
REQ-011 SHALL have port o_i_rdata, output, DATA_WIDTH, instruction read data.
REQ-012 SHALL have port i_d_req, input, 1, data request; held until granted.
REQ-013 SHALL have port i_d_we, input, 1, data request is a write.
REQ-014 SHALL have port i_d_be, input, DATA_BYTES, write byte enables.
REQ-015 SHALL have port i_d_addr, input, ADDR_WIDTH, data word address.
REQ-016 SHALL have port i_d_wdata, input, DATA_WIDTH, write data.
REQ-017 SHALL have port o_d_gnt, output, 1, data request accepted this cycle.
REQ-018 SHALL have port o_d_rvalid, output, 1, data response valid (reads and writes).
REQ-019 SHALL have port o_d_rdata, output, DATA_WIDTH, data read data.
REQ-020 SHALL have port o_mem_addr, output, ADDR_WIDTH, memory address.
REQ-021 SHALL have port o_mem_wdata, output, DATA_WIDTH, memory write data.
REQ-022 SHALL have port o_mem_wen, output, DATA_BYTES, memory per-byte write enable.
REQ-023 SHALL have port i_mem_rdata, input, DATA_WIDTH, memory read data, valid one cycle after address (write-first).

Function
REQ-024 SHALL grant at most one requester per cycle; o_i_gnt and o_d_gnt combinational from current requests and state, never both high.
REQ-025 SHALL grant data when only i_d_req is high, instruction when only i_i_req is high, nothing when neither.
REQ-026 SHALL, with both requesting, grant data unless starve counter equals STARVE_LIMIT, then grant instruction.
REQ-027 SHALL increment the 4-bit starve counter on each data grant while i_i_req is high; clear it on any instruction grant or any cycle with i_i_req low; never exceed STARVE_LIMIT.
REQ-028 SHALL drive o_mem_addr from the granted requester's address; with no grant, hold the previous o_mem_addr (registered last address).
REQ-029 SHALL drive o_mem_wen = i_d_be only when o_d_gnt and i_d_we are high, else all zeros; o_mem_wdata = i_d_wdata always.
REQ-030 SHALL never write memory on an instruction grant.
REQ-031 SHALL register the grant owner; one cycle after an instruction grant assert o_i_rvalid for exactly one cycle with o_i_rdata = i_mem_rdata.
REQ-032 SHALL one cycle after a data grant (read or write) assert o_d_rvalid for exactly one cycle with o_d_rdata = i_mem_rdata (post-write contents for writes).
REQ-033 SHALL allow back-to-back grants every cycle (full throughput, fixed latency 1).
REQ-034 SHALL drive o_i_rdata and o_d_rdata directly from i_mem_rdata regardless of rvalid.

Reset
REQ-035 SHALL, while rst_n is low, force o_i_rvalid = 0, o_d_rvalid = 0, starve counter = 0, registered address = 0, o_i_gnt = 0, o_d_gnt = 0, o_mem_wen = 0.
REQ-036 SHALL discard any response pending when reset asserts; no rvalid in the first cycle after release.

Verification
REQ-037 Instruction only: i_i_req=1, i_i_addr=0x010 -> o_i_gnt=1, o_mem_addr=0x010, o_mem_wen=0; next cycle o_i_rvalid=1, o_i_rdata=mem[0x010].
REQ-038 Byte write: i_d_req=1, i_d_we=1, i_d_be=4'b0010, addr 0x020, wdata 0xAABBCCDD on mem 0x11223344 -> o_mem_wen=4'b0010; next cycle o_d_rvalid=1, o_d_rdata=0x1122CC44.
REQ-039 Contention, STARVE_LIMIT=4: both requesting continuously -> grants D,D,D,D,I,D,D,D,D,I; counter never exceeds 4.
REQ-040 Counter clear: 3 data grants with i_i_req high, then i_i_req low one cycle, then both -> 4 more data grants before instruction grant.
REQ-041 Back-to-back: alternating I/D grants every cycle -> exactly one rvalid per cycle, routed to correct port, no lost or duplicated responses.
REQ-042 Reset mid-operation: data read granted, rst_n low before next edge -> o_d_rvalid stays 0, counter 0, o_mem_wen 0 throughout reset.
